// File: rtl/pulse_sync_mc.sv
// Multi-channel toggle-to-pulse synchronizer, receive side.
// Each channel buffers events in a pending counter and spaces its output pulses.
module pulse_sync_mc #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 2,
    parameter int MIN_GAP     = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] req_tgl,
    input  logic [CH-1:0] out_ready,
    input  logic [CH-1:0] ovf_clr,
    output logic [CH-1:0] out_pulse,
    output logic [CH-1:0] ack_tgl,
    output logic [CH-1:0] ovf,
    output logic          busy
);

    localparam logic [CNT_W-1:0] PMAX = '1;
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_N = PW'(SYNC_STAGES + 1);

    logic [CH-1:0]    sync [SYNC_STAGES];
    logic [CH-1:0]    prev;
    logic [PW-1:0]    prime_cnt;
    logic [CNT_W-1:0] pend [CH];
    logic [3:0]       gap  [CH];

    logic             primed;
    logic [CH-1:0]    s;
    logic [CH-1:0]    evt;
    logic [CH-1:0]    issue;
    logic [CH-1:0]    drop;
    logic [CNT_W-1:0] pend_nxt [CH];
    logic             any_pend;

    assign s      = sync[SYNC_STAGES-1];
    assign primed = (prime_cnt == PRIME_N);

    always_comb begin
        evt      = (s ^ prev) & {CH{primed}};
        issue    = '0;
        drop     = '0;
        any_pend = 1'b0;
        for (int i = 0; i < CH; i++) begin
            pend_nxt[i] = pend[i];
            any_pend    = any_pend | (pend[i] != '0);
            issue[i]    = ((pend[i] != '0) | evt[i]) & out_ready[i]
                          & (gap[i] == '0);
            drop[i]     = evt[i] & (pend[i] == PMAX) & ~issue[i];
            // Bypass: an event issued straight away nets to zero.
            pend_nxt[i] = pend[i] + CNT_W'(evt[i] & ~drop[i])
                          - CNT_W'(issue[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
            prev      <= '0;
            prime_cnt <= '0;
        end else begin
            sync[0] <= req_tgl;
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
            prev <= s;
            if (!primed) prime_cnt <= prime_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                pend[i] <= '0;
                gap[i]  <= '0;
            end
            out_pulse <= '0;
            ack_tgl   <= '0;
            ovf       <= '0;
            busy      <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                pend[i] <= pend_nxt[i];
                if (issue[i])
                    gap[i] <= 4'(MIN_GAP);
                else if (gap[i] != '0)
                    gap[i] <= gap[i] - 4'd1;
            end
            out_pulse <= issue;
            ack_tgl   <= ack_tgl ^ evt;
            // A drop coinciding with a clear keeps the flag set.
            ovf       <= (ovf | drop) & ~(ovf_clr & ~drop);
            busy      <= any_pend;
        end
    end

endmodule
